// File: rtl/e_mdu_pkg.sv
// mdu_defs: shared definitions for the execute-stage multiply/divide unit.
//   md_op_e        operation codes carried from decode
//   mdu_state_e    control state of the busy sequencer
//   is_start()     true for ops that launch a multi-cycle MULT/DIV
//   *_CYCLES_DEF   default latencies
package mdu_defs;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_start(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage request/response bundle for the multiply/divide unit.
//   master: drives en, md_op, A, B; observes busy, stall_req, HI, LO, rd_data
//   slave : the MDU side of the same signals
import mdu_defs::*;

interface e_mdu_if;
    logic        en;
    md_op_e      md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd_data;

    modport master (output en, md_op, A, B,
                    input  busy, stall_req, HI, LO, rd_data);
    modport slave  (input  en, md_op, A, B,
                    output busy, stall_req, HI, LO, rd_data);
endinterface

// File: rtl/e_mdu_calc.sv
// mdu_calc: combinational arithmetic core.
//   a, b       operands
//   is_signed  select signed (MULT/DIV) or unsigned (MULTU/DIVU) semantics
//   prod       64-bit product
//   quot, rem  quotient (toward zero) and remainder (sign of dividend)
//   div_zero   b == 0; quot/rem are meaningless when set
module mdu_calc (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, divisor, uq, ur;
    logic [63:0] ext_a, ext_b;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign ext_a = {{32{is_signed & a[31]}}, a};
    assign ext_b = {{32{is_signed & b[31]}}, b};
    assign prod  = ext_a * ext_b;

    // Divide magnitudes unsigned, then reapply signs. This also makes
    // 0x80000000 / -1 wrap cleanly to 0x80000000 with remainder 0.
    assign neg_a    = is_signed & a[31];
    assign neg_b    = is_signed & b[31];
    assign mag_a    = neg_a ? (32'd0 - a) : a;
    assign mag_b    = neg_b ? (32'd0 - b) : b;
    assign div_zero = (b == 32'd0);
    assign divisor  = div_zero ? 32'd1 : mag_b;
    assign uq       = mag_a / divisor;
    assign ur       = mag_a % divisor;
    assign quot     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem      = neg_a ? (32'd0 - ur) : ur;
endmodule

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO ownership.
//   clk, reset  clock; asynchronous active-high reset
//   bus         e_mdu_if.slave: en/md_op/A/B in; busy, stall_req, HI, LO,
//               rd_data out
// A start op is evaluated immediately and parked in temp_hi/temp_lo; the
// busy counter then models the latency before HI/LO are committed.
import mdu_defs::*;

module e_mdu #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    e_mdu_if.slave    bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] temp_hi, temp_hi_n, temp_lo, temp_lo_n;
    logic        temp_valid, temp_valid_n;
    logic [31:0] hi, hi_n, lo, lo_n;

    logic        is_mul, is_signed, div_zero;
    logic [63:0] prod;
    logic [31:0] quot, rem;

    assign is_mul    = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
    assign is_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);

    mdu_calc u_calc (
        .a        (bus.A),
        .b        (bus.B),
        .is_signed(is_signed),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            temp_hi    <= '0;
            temp_lo    <= '0;
            temp_valid <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            temp_hi    <= temp_hi_n;
            temp_lo    <= temp_lo_n;
            temp_valid <= temp_valid_n;
            hi         <= hi_n;
            lo         <= lo_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        temp_hi_n    = temp_hi;
        temp_lo_n    = temp_lo;
        temp_valid_n = temp_valid;
        hi_n         = hi;
        lo_n         = lo;
        case (state)
            S_IDLE: begin
                if (bus.en) begin
                    if (is_start(bus.md_op)) begin
                        state_n      = S_BUSY;
                        cnt_n        = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        temp_hi_n    = is_mul ? prod[63:32] : rem;
                        temp_lo_n    = is_mul ? prod[31:0]  : quot;
                        // Divide by zero still burns the latency but never commits.
                        temp_valid_n = is_mul | ~div_zero;
                    end else if (bus.md_op == MD_MTHI) begin
                        hi_n = bus.A;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_n = bus.A;
                    end
                end
            end
            S_BUSY: begin
                // All E-stage ops are ignored here; only the countdown runs.
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = S_IDLE;
                    if (temp_valid) begin
                        hi_n = temp_hi;
                        lo_n = temp_lo;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.busy      = (state == S_BUSY);
    assign bus.stall_req = bus.busy | (bus.en & is_start(bus.md_op));
    assign bus.HI        = hi;
    assign bus.LO        = lo;
    assign bus.rd_data   = (bus.md_op == MD_MFHI) ? hi :
                           (bus.md_op == MD_MFLO) ? lo : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
import mdu_defs::*;

module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference: architectural result of a start op from plain arithmetic.
    function automatic void ref_start(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l,
                                      output bit upd, output int lat);
        longint sa, sb, q, r, sp;
        longint unsigned up, ua, ub;
        h = 32'd0; l = 32'd0; upd = 1'b1; lat = MC;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            MD_MULT:  begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            MD_MULTU: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            MD_DIV: begin
                lat = DC;
                if (b == 32'd0) upd = 1'b0;
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            MD_DIVU: begin
                lat = DC;
                if (b == 32'd0) upd = 1'b0;
                else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
            end
            default: upd = 1'b0;
        endcase
    endfunction

    task automatic drive(input logic e, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.en = e; bus.md_op = op; bus.A = a; bus.B = b;
    endtask

    // One op at a negedge, held through the next rising edge.
    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(1'b1, op, a, b);
        @(posedge clk);
        #1 drive(1'b0, MD_NONE, 32'd0, 32'd0);
    endtask

    // Start op from idle: checks stall_req, busy length and final HI/LO.
    task automatic run_start(input string name, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        bit upd;
        int lat, n;
        ref_start(op, a, b, eh, el, upd, lat);
        if (!upd) begin eh = m_hi; el = m_lo; end
        @(negedge clk);
        drive(1'b1, op, a, b);
        #1;
        checks++;
        if (bus.stall_req !== 1'b1) begin
            failures++; $display("FAIL %s_stall got=%b want=1", name, bus.stall_req);
        end
        @(posedge clk);
        #1 drive(1'b0, MD_NONE, 32'd0, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != lat) begin failures++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, n, lat); end
        checks++;
        if (bus.HI !== eh || bus.LO !== el) begin
            failures++;
            $display("FAIL %s_result got HI=%h LO=%h want HI=%h LO=%h", name, bus.HI, bus.LO, eh, el);
        end
        m_hi = eh; m_lo = el;
    endtask

    task automatic test_reset();
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got busy=%b HI=%h LO=%h stall=%b want 0/0/0/0",
                     bus.busy, bus.HI, bus.LO, bus.stall_req);
        end
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_reset_mid_mult();
        do_op(MD_MTHI, 32'h000000AA, 32'd0);
        do_op(MD_MTLO, 32'h000000BB, 32'd0);
        do_op(MD_MULT, 32'd3, 32'd5);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b HI=%h LO=%h want 0/0/0", bus.busy, bus.HI, bus.LO);
        end
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_commit got busy=%b HI=%h LO=%h want 0/0/0", bus.busy, bus.HI, bus.LO);
        end
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_mult();
        run_start("mult", MD_MULT, 32'hFFFFFFFF, 32'd2);
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFE) begin
            failures++; $display("FAIL mult_const got %h_%h want ffffffff_fffffffe", bus.HI, bus.LO);
        end
        run_start("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2);
        checks++;
        if (bus.HI !== 32'h00000001 || bus.LO !== 32'hFFFFFFFE) begin
            failures++; $display("FAIL multu_const got %h_%h want 00000001_fffffffe", bus.HI, bus.LO);
        end
    endtask

    task automatic test_div();
        run_start("div", MD_DIV, 32'hFFFFFFF9, 32'd2);
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
            failures++; $display("FAIL div_const got HI=%h LO=%h want ffffffff/fffffffd", bus.HI, bus.LO);
        end
        run_start("divu", MD_DIVU, 32'd7, 32'd2);
        checks++;
        if (bus.HI !== 32'd1 || bus.LO !== 32'd3) begin
            failures++; $display("FAIL divu_const got HI=%h LO=%h want 1/3", bus.HI, bus.LO);
        end
        run_start("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'h80000000) begin
            failures++; $display("FAIL div_ovf_const got HI=%h LO=%h want 0/80000000", bus.HI, bus.LO);
        end
    endtask

    task automatic test_div_zero();
        do_op(MD_MTHI, 32'h11, 32'd0);
        do_op(MD_MTLO, 32'h22, 32'd0);
        m_hi = 32'h11; m_lo = 32'h22;
        run_start("divz", MD_DIV, 32'd5, 32'd0);
        checks++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
            failures++; $display("FAIL divz_keep got HI=%h LO=%h want 11/22", bus.HI, bus.LO);
        end
        run_start("divuz", MD_DIVU, 32'd9, 32'd0);
    endtask

    task automatic test_mt_mf();
        do_op(MD_MTHI, 32'hDEADBEEF, 32'd0);
        @(negedge clk);
        drive(1'b1, MD_MFHI, 32'd0, 32'd0);
        #1;
        checks++;
        if (bus.rd_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mfhi got=%h want=deadbeef", bus.rd_data);
        end
        @(posedge clk);
        #1 drive(1'b0, MD_NONE, 32'd0, 32'd0);
        do_op(MD_MTLO, 32'h1234, 32'd0);
        @(negedge clk);
        checks++;
        if (bus.LO !== 32'h1234 || bus.HI !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mtlo got HI=%h LO=%h want deadbeef/1234", bus.HI, bus.LO);
        end
        m_hi = 32'hDEADBEEF; m_lo = 32'h1234;
    endtask

    task automatic test_busy_ignore();
        do_op(MD_MULT, 32'd3, 32'd4);
        for (int i = 1; i <= MC + 1; i++) begin
            @(negedge clk);
            case (i)
                1: drive(1'b1, MD_MFLO, 32'd0, 32'd0);
                2: drive(1'b1, MD_MULT, 32'd7, 32'd7);
                3: drive(1'b1, MD_MTLO, 32'h99, 32'd0);
                4: drive(1'b1, MD_MTHI, 32'h77, 32'd0);
                default: drive(1'b0, MD_NONE, 32'd0, 32'd0);
            endcase
            #1;
            checks++;
            if (bus.busy !== (i <= MC)) begin
                failures++; $display("FAIL busy_ign_busy cyc=%0d got=%b want=%b", i, bus.busy, i <= MC);
            end
            if (i == 1) begin
                checks++;
                if (bus.rd_data !== 32'h1234) begin
                    failures++; $display("FAIL mflo_during_busy got=%h want=00001234", bus.rd_data);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.stall_req !== 1'b1) begin
                    failures++; $display("FAIL stall_while_busy got=%b want=1", bus.stall_req);
                end
            end
        end
        checks++;
        if (bus.LO !== 32'd12 || bus.HI !== 32'd0) begin
            failures++; $display("FAIL busy_ign_result got HI=%h LO=%h want 0/c", bus.HI, bus.LO);
        end
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        m_hi = 0; m_lo = 12;
    endtask

    task automatic test_stall_req();
        @(negedge clk);
        drive(1'b1, MD_MULT, 32'd2, 32'd2);
        #1;
        checks++;
        if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL stall_start got=%b want=1", bus.stall_req); end
        drive(1'b0, MD_DIV, 32'd2, 32'd2);
        #1;
        checks++;
        if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL stall_en0 got=%b want=0", bus.stall_req); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== m_hi || bus.LO !== m_lo) begin
            failures++; $display("FAIL en0_no_start got busy=%b HI=%h LO=%h want 0/%h/%h", bus.busy, bus.HI, bus.LO, m_hi, m_lo);
        end
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
    endtask

    task automatic test_random();
        md_op_e op;
        logic [31:0] a, b;
        for (int k = 0; k < 40; k++) begin
            op = md_op_e'($urandom_range(0, 8));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hF;
            if (is_start(op)) begin
                run_start("rand", op, a, b);
            end else begin
                @(negedge clk);
                drive(1'b1, op, a, b);
                #1;
                checks++;
                if (bus.stall_req !== 1'b0 ||
                    bus.rd_data !== ((op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0)) begin
                    failures++; $display("FAIL rand_read op=%0d got rd=%h stall=%b", op, bus.rd_data, bus.stall_req);
                end
                @(posedge clk);
                #1 drive(1'b0, MD_NONE, 32'd0, 32'd0);
                if (op == MD_MTHI) m_hi = a;
                if (op == MD_MTLO) m_lo = a;
                @(negedge clk);
                checks++;
                if (bus.HI !== m_hi || bus.LO !== m_lo || bus.busy !== 1'b0) begin
                    failures++; $display("FAIL rand_state op=%0d got HI=%h LO=%h want %h/%h", op, bus.HI, bus.LO, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mult();
        test_mult();
        test_div();
        test_div_zero();
        test_mt_mf();
        test_busy_ignore();
        test_stall_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
